// File: rtl/mantissa_aligner.sv
// Pre-add mantissa alignment: iterative right shift of a WIDTH-bit mantissa
// (hidden bit included) by an exponent difference, at most STEP bits per cycle,
// producing guard, round and sticky bits for the rounding stage.
module mantissa_aligner #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned SHIFT_W = 8,
    parameter int unsigned STEP    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mantissa_in,
    input  logic [SHIFT_W-1:0] shift_amount,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   mantissa_out,
    output logic               guard,
    output logic               round_bit,
    output logic               sticky
);

    // Shifts beyond the full work width (mantissa + guard + round) are clamped;
    // the remaining counter only ever needs to hold 0..WIDTH+2.
    localparam int unsigned LIM = WIDTH + 2;
    localparam int unsigned CW  = $clog2(LIM + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [LIM-1:0]   work_q;
    logic             sticky_q;
    logic [CW-1:0]    remaining_q;
    logic             out_valid_q;

    logic [CW-1:0]    eff_d;
    logic [CW-1:0]    step_k_d;
    logic [LIM-1:0]   step_mask_d;
    logic [LIM-1:0]   work_d;
    logic             sticky_d;

    // Clamp the requested shift and compute one iteration's shift, mask and results
    always_comb begin
        eff_d       = '0;
        step_k_d    = '0;
        step_mask_d = '0;
        work_d      = '0;
        sticky_d    = 1'b0;

        if (32'(shift_amount) >= LIM)
            eff_d = CW'(LIM);
        else
            eff_d = CW'(shift_amount);

        if (remaining_q < CW'(STEP))
            step_k_d = remaining_q;
        else
            step_k_d = CW'(STEP);

        step_mask_d = ~({LIM{1'b1}} << step_k_d);
        work_d      = work_q >> step_k_d;
        sticky_d    = sticky_q | (|(work_q & step_mask_d));
    end

    // Control FSM and datapath registers; en=0 freezes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            sticky_q    <= 1'b0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q      <= {mantissa_in, 2'b00};
                        sticky_q    <= 1'b0;
                        remaining_q <= eff_d;
                        if (eff_d == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_q      <= work_d;
                    sticky_q    <= sticky_d;
                    remaining_q <= remaining_q - step_k_d;
                    if (remaining_q == step_k_d) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Result outputs come straight from the work register and sticky flag
    always_comb begin
        in_ready     = (state_q == IDLE) && en;
        out_valid    = out_valid_q;
        mantissa_out = work_q[LIM-1:2];
        guard        = work_q[1];
        round_bit    = work_q[0];
        sticky       = sticky_q;
    end

endmodule

// File: tb/tb_mantissa_aligner.sv
// Directed bench for mantissa_aligner (WIDTH=24, SHIFT_W=8, STEP=4).
module tb_mantissa_aligner;

    logic        clk;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] mantissa_in;
    logic [7:0]  shift_amount;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] mantissa_out;
    logic        guard;
    logic        round_bit;
    logic        sticky;

    int checks = 0;
    int errors = 0;

    mantissa_aligner #(
        .WIDTH   (24),
        .SHIFT_W (8),
        .STEP    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mantissa_in  (mantissa_in),
        .shift_amount (shift_amount),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mantissa_out (mantissa_out),
        .guard        (guard),
        .round_bit    (round_bit),
        .sticky       (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns the number of edges waited.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 60) begin
            tick();
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input logic [23:0] m,
                                input logic g, input logic r, input logic s);
        check({tag, "_mant"}, 32'(mantissa_out), 32'(m));
        check({tag, "_guard"}, 32'(guard), 32'(g));
        check({tag, "_round"}, 32'(round_bit), 32'(r));
        check({tag, "_sticky"}, 32'(sticky), 32'(s));
    endtask

    // One full transaction with out_ready held high.
    task automatic do_op(input string tag, input logic [23:0] mant, input logic [7:0] sh,
                         input int exp_edges, input logic [23:0] exp_m,
                         input logic exp_g, input logic exp_r, input logic exp_s);
        int edges;
        out_ready    = 1'b1;
        mantissa_in  = mant;
        shift_amount = sh;
        in_valid     = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(edges);
        check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
        check_result(tag, exp_m, exp_g, exp_r, exp_s);
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_hold_mant"}, 32'(mantissa_out), 32'(exp_m));
    endtask

    initial begin
        int edges;
        reset        = 1'b1;
        en           = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        mantissa_in  = '0;
        shift_amount = '0;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check_result("rst", 24'h000000, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Main function
        do_op("t1", 24'h800001, 8'd5,   2, 24'h040000, 1'b0, 1'b0, 1'b1);
        do_op("t2", 24'hFFFFFF, 8'd2,   1, 24'h3FFFFF, 1'b1, 1'b1, 1'b0);
        do_op("t3", 24'hABCDEF, 8'd0,   0, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        do_op("t4", 24'h000001, 8'd200, 7, 24'h000000, 1'b0, 1'b0, 1'b1);
        do_op("t4b", 24'h800000, 8'd25, 7, 24'h000000, 1'b0, 1'b1, 1'b0);
        do_op("t4c", 24'h800000, 8'd26, 7, 24'h000000, 1'b0, 1'b0, 1'b1);
        do_op("t4d", 24'hC00000, 8'd24, 6, 24'h000000, 1'b1, 1'b1, 1'b0);
        do_op("zero", 24'h000000, 8'd3, 1, 24'h000000, 1'b0, 1'b0, 1'b0);
        do_op("s8", 24'h123456, 8'd8,   2, 24'h001234, 1'b0, 1'b1, 1'b1);

        // Backpressure in DONE
        out_ready    = 1'b0;
        mantissa_in  = 24'hFFFFFF;
        shift_amount = 8'd2;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(edges);
        check("bp_latency", 32'(edges), 32'd1);
        mantissa_in  = 24'h111111;
        shift_amount = 8'd0;
        in_valid     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check_result("bp", 24'h3FFFFF, 1'b1, 1'b1, 1'b0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        do_op("bp_next", 24'h111111, 8'd0, 0, 24'h111111, 1'b0, 1'b0, 1'b0);

        // Reset mid-SHIFT
        mantissa_in  = 24'hFFFFFF;
        shift_amount = 8'd20;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check_result("mid_rst", 24'h000000, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        edges = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) edges++;
        end
        check("mid_rst_no_pulse", 32'(edges), 32'd0);

        // en low for 3 cycles mid-SHIFT: latency 5 -> 8
        mantissa_in  = 24'hFFFFFF;
        shift_amount = 8'd20;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("en_freeze_ready", 32'(in_ready), 32'd0);
            check("en_freeze_valid", 32'(out_valid), 32'd0);
            tick();
        end
        en = 1'b1;
        wait_valid(edges);
        check("en_latency", 32'(edges + 5), 32'd8);
        check_result("en", 24'h00000F, 1'b1, 1'b1, 1'b1);
        tick();
        check("en_done_drop", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
